// File: rtl/gray_2_bin_arbiter.sv
// Round-robin front end that time-shares a single Gray-to-binary converter
// among NUM_REQ requesters and returns each result tagged with its owner.

// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray_2_bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic acc;

    // Running XOR from the MSB down produces the binary word bit by bit.
    always_comb begin
        acc   = 1'b0;
        bin_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// state | meaning
// IDLE  | waiting for a request; grants the round-robin winner combinationally
// CONV  | captured Gray word is on the converter input; result latched on exit
// RESP  | response valid, held stable until rsp_ready_i
module gray_2_bin_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_gray_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       rsp_valid_o,
    output logic [WIDTH-1:0]           rsp_bin_o,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    input  logic                       rsp_ready_i,
    output logic                       busy_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     ptr_d;
    logic [WIDTH-1:0]    gray_q;
    logic [ID_W-1:0]     id_q;
    logic [WIDTH-1:0]    rsp_bin_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic                rsp_valid_q;

    logic                grant_any;
    logic [ID_W-1:0]     grant_id;
    logic [NUM_REQ-1:0]  grant_vec;
    logic [WIDTH-1:0]    grant_word;
    logic [ID_W:0]       cand;
    logic [WIDTH-1:0]    conv_bin;

    // Search for the first valid requester starting at the priority pointer,
    // wrapping modulo NUM_REQ (one extra bit keeps the sum from overflowing).
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (cand >= (ID_W + 1)'(NUM_REQ)) begin
                cand = cand - (ID_W + 1)'(NUM_REQ);
            end
            if (!grant_any && req_valid_i[cand[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = cand[ID_W-1:0];
            end
        end
    end

    // One-hot grant, selected Gray word and the pointer value after acceptance.
    always_comb begin
        grant_vec  = '0;
        grant_word = '0;
        if (grant_any) begin
            grant_vec[grant_id] = 1'b1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_vec[k]) begin
                grant_word = req_gray_i[k*WIDTH +: WIDTH];
            end
        end
        if (grant_id == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_id + 1'b1;
        end
    end

    gray_2_bin #(.WIDTH(WIDTH)) u_conv (
        .gray_i (gray_q),
        .bin_o  (conv_bin)
    );

    // Sequencing: capture on grant, latch the conversion, hold until drained.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gray_q      <= '0;
            id_q        <= '0;
            rsp_bin_q   <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        gray_q  <= grant_word;
                        id_q    <= grant_id;
                        ptr_q   <= ptr_d;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    rsp_bin_q   <= conv_bin;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Grants are only offered in IDLE and are suppressed while reset is held.
    assign req_ready_o = (state_q == S_IDLE && !rst_i) ? grant_vec : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_bin_o   = rsp_bin_q;
    assign rsp_id_o    = rsp_id_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_gray_2_bin_arbiter.sv
// Self-checking bench for gray_2_bin_arbiter: directed vectors plus a
// randomized run against a queue-based reference model.
module tb_gray_2_bin_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ*WIDTH-1:0] req_gray_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic                     rsp_valid_o;
    logic [WIDTH-1:0]         rsp_bin_o;
    logic [ID_W-1:0]          rsp_id_o;
    logic                     rsp_ready_i;
    logic                     busy_o;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int         id;
        logic [7:0] gray;
        logic [7:0] exp_bin;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] bin;
    } exp_t;

    vec_t vecs [8];

    exp_t               q [$];
    logic [NUM_REQ-1:0] pend;
    logic [WIDTH-1:0]   pw [NUM_REQ];
    int                 mptr, age, n_acc, cyc, g;
    bit                 rc_done, rr_done, just_rst, exp_rv;
    int                 rr_order [5];
    logic [7:0]         rr_bin [5];
    int                 n_grant, n_rsp;
    logic [NUM_REQ-1:0] exp_ready;

    gray_2_bin_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_gray_i  (req_gray_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_bin_o   (rsp_bin_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_ready_i (rsp_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Binary value is the XOR of the Gray word with all of its right shifts.
    function automatic logic [WIDTH-1:0] ref_bin(input logic [WIDTH-1:0] gw);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int s = 0; s < WIDTH; s++) b = b ^ (gw >> s);
        return b;
    endfunction

    function automatic int ref_grant(input int ptr, input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++)
            if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int k, input logic [WIDTH-1:0] w);
        req_gray_i[k*WIDTH +: WIDTH] = w;
    endtask

    task automatic do_reset(input int n);
        rst_i       = 1'b1;
        req_valid_i = '0;
        repeat (n) tick();
        rst_i = 1'b0;
    endtask

    // One isolated transaction with rsp_ready_i high; called just after an edge.
    task automatic single_txn(input int k, input logic [7:0] gw, input logic [7:0] eb);
        logic [NUM_REQ-1:0] oh;
        oh          = '0;
        oh[k]       = 1'b1;
        rsp_ready_i = 1'b1;
        req_valid_i = oh;
        set_word(k, gw);
        @(negedge clk);
        chk("vec_grant", req_ready_o, oh);
        chk("vec_busy_idle", busy_o, 0);
        tick();
        req_valid_i = '0;
        set_word(k, ~gw);
        @(negedge clk);
        chk("vec_conv_ready", req_ready_o, 0);
        chk("vec_conv_busy", busy_o, 1);
        chk("vec_conv_rvalid", rsp_valid_o, 0);
        tick();
        @(negedge clk);
        chk("vec_rsp_valid", rsp_valid_o, 1);
        chk("vec_rsp_bin", rsp_bin_o, eb);
        chk("vec_rsp_id", rsp_id_o, k);
        tick();
        @(negedge clk);
        chk("vec_after_rvalid", rsp_valid_o, 0);
        chk("vec_after_busy", busy_o, 0);
        tick();
    endtask

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2, 8'h80, 8'hFF};
        vecs[1] = '{0, 8'h00, 8'h00};
        vecs[2] = '{1, 8'hFF, 8'hAA};
        vecs[3] = '{2, 8'hAA, 8'hCC};
        vecs[4] = '{3, 8'h80, 8'hFF};
        vecs[5] = '{1, 8'h01, 8'h01};
        vecs[6] = '{3, 8'hC0, 8'h80};
        vecs[7] = '{0, 8'h55, 8'h66};

        rsp_ready_i = 1'b0;
        req_gray_i  = '0;
        req_valid_i = '0;
        rst_i       = 1'b1;
        #1;

        // Reset and idle
        do_reset(3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {req_ready_o, rsp_valid_o, rsp_bin_o, 6'(rsp_id_o), busy_o}, 0);
            tick();
        end

        // Single request held valid: grant, result 2 cycles later, regrant at +3
        rsp_ready_i = 1'b1;
        req_valid_i = 4'b0100;
        set_word(2, 8'h80);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("single_ready", req_ready_o, (c == 0 || c == 3) ? 4'b0100 : 4'b0000);
            if (c == 2) begin
                chk("single_rvalid", rsp_valid_o, 1);
                chk("single_bin", rsp_bin_o, 8'hFF);
                chk("single_id", rsp_id_o, 2);
            end
            if (c == 3) req_valid_i = '0;
            tick();
        end

        // Table of isolated conversions
        for (int i = 0; i < 8; i++) single_txn(vecs[i].id, vecs[i].gray, vecs[i].exp_bin);

        // Round-robin fairness from pointer 0
        do_reset(1);
        rsp_ready_i = 1'b1;
        set_word(0, 8'h00);
        set_word(1, 8'hFF);
        set_word(2, 8'hAA);
        set_word(3, 8'h80);
        req_valid_i = 4'b1111;
        rr_order = '{0, 1, 2, 3, 0};
        rr_bin   = '{8'h00, 8'hAA, 8'hCC, 8'hFF, 8'h00};
        n_grant  = 0;
        n_rsp    = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (req_ready_o != 0) begin
                if (n_grant < 5) chk("rr_grant", req_ready_o, 1 << rr_order[n_grant]);
                n_grant++;
            end
            if (rsp_valid_o) begin
                if (n_rsp < 5) begin
                    chk("rr_bin", rsp_bin_o, rr_bin[n_rsp]);
                    chk("rr_id", rsp_id_o, rr_order[n_rsp]);
                end
                n_rsp++;
            end
            tick();
        end
        req_valid_i = '0;
        chk("rr_grant_count", n_grant, 5);
        chk("rr_rsp_count", n_rsp, 5);
        repeat (3) tick();

        // Pointer wrap: grant 3 moves the pointer to 0, then 0 beats 3
        single_txn(3, 8'h01, 8'h01);
        req_valid_i = 4'b1001;
        set_word(0, 8'h80);
        set_word(3, 8'hFF);
        @(negedge clk);
        chk("wrap_first", req_ready_o, 4'b0001);
        tick();
        req_valid_i = 4'b1000;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                chk("wrap_first_id", rsp_id_o, 0);
                chk("wrap_first_bin", rsp_bin_o, 8'hFF);
            end
            chk("wrap_second", req_ready_o, (c == 3) ? 4'b1000 : 4'b0000);
            tick();
        end
        req_valid_i = '0;
        @(negedge clk);
        chk("wrap_second_busy", busy_o, 1);
        tick();
        @(negedge clk);
        chk("wrap_second_id", rsp_id_o, 3);
        chk("wrap_second_bin", rsp_bin_o, 8'hAA);
        repeat (2) tick();

        // Backpressure: 5 stalled RESP cycles while inputs churn
        rsp_ready_i = 1'b0;
        req_valid_i = 4'b0010;
        set_word(1, 8'h55);
        @(negedge clk);
        chk("bp_grant", req_ready_o, 4'b0010);
        tick();
        req_valid_i = 4'b0001;
        set_word(0, 8'h80);
        set_word(1, 8'h3C);
        @(negedge clk);
        chk("bp_conv_ready", req_ready_o, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            set_word(1, 8'($urandom_range(0, 255)));
            set_word(2, 8'($urandom_range(0, 255)));
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid_o, 1);
            chk("bp_hold_bin", rsp_bin_o, 8'h66);
            chk("bp_hold_id", rsp_id_o, 1);
            chk("bp_hold_ready", req_ready_o, 0);
            tick();
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", rsp_valid_o, 1);
        chk("bp_release_bin", rsp_bin_o, 8'h66);
        tick();
        @(negedge clk);
        chk("bp_single_rsp", rsp_valid_o, 0);
        chk("bp_next_grant", req_ready_o, 4'b0001);
        tick();
        req_valid_i = '0;
        repeat (3) tick();

        // Randomized run against the queue model, with two mid-flight resets
        do_reset(1);
        pend     = '0;
        q.delete();
        mptr     = 0;
        age      = 0;
        n_acc    = 0;
        cyc      = 0;
        rc_done  = 0;
        rr_done  = 0;
        just_rst = 0;
        for (int k = 0; k < NUM_REQ; k++) pw[k] = '0;
        while (n_acc < 1000 && cyc < 20000) begin
            cyc++;
            rst_i = 1'b0;
            if (!rc_done && n_acc > 300 && q.size() > 0 && age == 1) begin
                rst_i   = 1'b1;
                rc_done = 1;
            end else if (!rr_done && n_acc > 600 && q.size() > 0 && age >= 2) begin
                rst_i   = 1'b1;
                rr_done = 1;
            end
            rsp_ready_i = 1'($urandom_range(0, 1));
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k] = 1'b1;
                    pw[k]   = 8'($urandom_range(0, 255));
                end
                if (pend[k]) set_word(k, pw[k]);
                else         set_word(k, 8'($urandom_range(0, 255)));
            end
            req_valid_i = pend;
            @(negedge clk);
            g      = -1;
            exp_rv = 0;
            if (rst_i) begin
                chk("rnd_ready_in_reset", req_ready_o, 0);
            end else begin
                exp_rv = (q.size() > 0) && (age >= 2);
                chk("rnd_rsp_valid", rsp_valid_o, exp_rv);
                chk("rnd_busy", busy_o, q.size() > 0);
                if (just_rst) begin
                    chk("rnd_reset_bin", rsp_bin_o, 0);
                    chk("rnd_reset_id", rsp_id_o, 0);
                end
                if (exp_rv) begin
                    chk("rnd_bin", rsp_bin_o, q[0].bin);
                    chk("rnd_id", rsp_id_o, q[0].id);
                end
                if (q.size() == 0) g = ref_grant(mptr, pend);
                exp_ready = '0;
                if (g >= 0) exp_ready[g] = 1'b1;
                chk("rnd_ready", req_ready_o, exp_ready);
            end
            just_rst = 0;
            if (rst_i) begin
                q.delete();
                mptr     = 0;
                age      = 0;
                just_rst = 1;
            end else if (g >= 0) begin
                q.push_back('{g, ref_bin(pw[g])});
                mptr    = (g + 1) % NUM_REQ;
                pend[g] = 1'b0;
                age     = 1;
                n_acc++;
            end else if (exp_rv && rsp_ready_i) begin
                void'(q.pop_front());
                age = 0;
            end else if (q.size() > 0) begin
                age++;
            end
            tick();
        end
        rst_i = 1'b0;
        chk("rnd_accept_budget", (n_acc >= 1000) ? 1 : 0, 1);
        chk("rnd_reset_conv_hit", rc_done, 1);
        chk("rnd_reset_resp_hit", rr_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_2_bin_arbiter.md
# gray_2_bin_arbiter

Round-robin controller that shares one `gray_2_bin` converter instance among `NUM_REQ` requesters. Each requester submits a Gray-coded word through a valid/ready handshake. The block grants one requester at a time and drives the captured word into the internal converter. It returns the registered binary result, tagged with the requester index, on a single valid/ready response port.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 8: Gray/binary word width, ≥2; passed to the internal `gray_2_bin #(.WIDTH(WIDTH))`.
- `ID_W`, `$clog2(NUM_REQ)`: width of the response requester index (localparam).

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_gray_i`  in  NUM_REQ*WIDTH  request words; requester k occupies bits [k*WIDTH +: WIDTH].
- `req_ready_o`  out  NUM_REQ  one-hot grant/accept; a request is accepted when `req_valid_i[k] & req_ready_o[k]`.
- `rsp_valid_o`  out  1  response valid.
- `rsp_bin_o`  out  WIDTH  binary result.
- `rsp_id_o`  out  ID_W  index of the requester that owns the response.
- `rsp_ready_i`  in  1  downstream accepts the response.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: if any `req_valid_i` bit is set, grant, capture the word and id, then go to CONV. Otherwise stay in IDLE.
  - CONV: feed the captured Gray word to `gray_2_bin`, latch `bin_o` into the response register, then go to RESP.
  - RESP: hold `rsp_valid_o`=1. When `rsp_ready_i`=1, go to IDLE; otherwise stay in RESP.
- Arbitration:
  - Priority pointer `ptr` (ID_W bits), reset value 0.
  - Grant the first index k with `req_valid_i[k]`=1, searching ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - On acceptance, `ptr` ← (k+1) mod NUM_REQ. Wrap from NUM_REQ-1 goes to 0.
  - `ptr` is unchanged when nothing is accepted.
- `req_ready_o` is combinational from state, `req_valid_i` and `ptr`.
  - It is nonzero only in IDLE, and only for the granted index.
  - It is all-zero in CONV, RESP and during reset.
  - `req_ready_o[k]` never asserts while `req_valid_i[k]`=0.
- Requesters must hold valid and data stable until accepted. The block does not capture un-granted words.
- The Gray word, id and result are registered. Changes on `req_gray_i` after acceptance do not affect the result.
- `rsp_bin_o` must equal the reference model: b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
- `rsp_bin_o` and `rsp_id_o` are held stable while `rsp_valid_o & !rsp_ready_i`.
- Reset values: state IDLE, `ptr`=0, `req_ready_o`=0, `rsp_valid_o`=0, `rsp_bin_o`=0, `rsp_id_o`=0, `busy_o`=0.
- Reset mid-operation (CONV or RESP): the in-flight transaction is discarded and no response is produced. Outputs take their reset values in the cycle after the reset edge.

## Timing
- Accept at edge T (in IDLE) → CONV in cycle T+1 → `rsp_valid_o`=1 from cycle T+2.
- Latency from accept to first `rsp_valid_o`: 2 cycles.
- With `rsp_ready_i` tied high, RESP lasts 1 cycle and the next accept happens in IDLE at T+3. Sustained throughput is one transaction per 3 cycles.
- Backpressure: each cycle `rsp_ready_i`=0 in RESP adds one cycle. No request is accepted meanwhile.
- Simultaneous requests: exactly one grant per IDLE cycle; the others stay pending with ready low.
- A requester deasserting valid before acceptance is legal; it is simply not granted.
- `busy_o` is high in CONV and RESP and low in IDLE.

## Test plan
- Reset/idle: hold `rst_i`=1 for 3 cycles, then release with no requests. Required: every output is 0 and `busy_o`=0 for 10 cycles.
- Single request: requester 2 sends Gray 8'h80 with `rsp_ready_i`=1. Required: `req_ready_o`=4'b0100 for one cycle; 2 cycles later `rsp_bin_o`=8'hFF, `rsp_id_o`=2; next accept possible 3 cycles after the first.
- Round-robin fairness: all 4 requesters hold valid, with words 8'h00, 8'hFF, 8'hAA, 8'h80. Required: grant order 0,1,2,3,0; results 8'h00, 8'hAA, 8'hCC, 8'hFF tagged with ids 0..3.
- Pointer wrap: after requester 3 is granted, requesters 0 and 3 assert. Required: 0 is granted first, then 3.
- Backpressure: hold `rsp_ready_i`=0 for 5 cycles in RESP while changing `req_gray_i`. Required: response stable, `req_ready_o`=0, one response only after ready rises.
- Random plus reset: 1000 random words from random requesters with random `rsp_ready_i`, checked by the scoreboard model. Assert `rst_i` once during CONV and once during RESP. Required: no response emitted for the aborted transactions, `ptr` returns to 0, zero mismatches.
